// File: rtl/mole_spawner_pkg.sv
// Shared types and helpers for the whack-a-mole spawner: FSM states,
// LFSR taps and the LFSR-field to one-hot mole mask mapping.
package whack_pkg;

  localparam int unsigned N_LEDS_DEF = 18;
  localparam logic [15:0] LFSR_TAPS  = 16'hB400;

  typedef logic [N_LEDS_DEF-1:0] led_t;

  typedef enum logic [2:0] {
    IDLE,
    SPAWN,
    SHOW,
    CLEAR,
    GAP
  } state_t;

  // Fields past the last LED fold back onto the low positions.
  function automatic led_t field_onehot(input logic [4:0] f);
    logic [4:0] pos;
    pos = (f >= 5'd18) ? (f - 5'd18) : f;
    return led_t'(1) << pos;
  endfunction

  function automatic led_t mole_mask(input logic [15:0] l, input logic [1:0] d);
    led_t m;
    m = field_onehot(l[4:0]);
    if (d != 2'd0) m = m | field_onehot(l[9:5]);
    if (d >= 2'd2) m = m | field_onehot(l[14:10]);
    return m;
  endfunction

endpackage

// File: rtl/mole_spawner_lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), left shift with feedback
// into bit 0; reloads the seed if it ever reaches the all-zero lock state.
module lfsr16
  import whack_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        step,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= seed;
    end else if (q == '0) begin
      q <= seed;
    end else if (step) begin
      q <= {q[14:0], ^(q & LFSR_TAPS)};
    end
  end

endmodule

// File: rtl/mole_spawner.sv
// Whack-a-mole round sequencer: spawns pseudo-random moles, scores the
// player's switches while they are shown, and paces rounds of a game.
module mole_spawner
  import whack_pkg::*;
#(
  parameter int unsigned N_LEDS     = 18,
  parameter logic [15:0] SEED       = 16'hACE1,
  parameter int unsigned SHOW_TICKS = 8,
  parameter int unsigned GAP_TICKS  = 2,
  parameter int unsigned N_ROUNDS   = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tick,
  input  logic [1:0]        difficulty,
  input  logic [N_LEDS-1:0] whacked,
  output logic [N_LEDS-1:0] led,
  output logic [N_LEDS-1:0] hits,
  output logic [N_LEDS-1:0] misses,
  output logic              round_done,
  output logic              game_over,
  output logic [7:0]        round_count,
  output logic              busy
);

  localparam logic [7:0] ROUNDS   = 8'(N_ROUNDS);
  localparam logic [7:0] SHOW_LEN = 8'(SHOW_TICKS);
  localparam logic [7:0] GAP_LAST = 8'(GAP_TICKS - 1);

  state_t state, state_n;
  logic [N_LEDS-1:0] led_n, hits_n, misses_n;
  logic [7:0] tick_cnt, tick_cnt_n, show_len, show_len_n, round_count_n;
  logic [7:0] show_scaled;
  logic round_done_n, game_over_n, lfsr_step, last_round;
  logic [15:0] lfsr_q;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .step  (lfsr_step),
    .seed  (SEED),
    .q     (lfsr_q)
  );

  assign show_scaled = SHOW_LEN >> difficulty;
  assign last_round  = (round_count == ROUNDS - 8'd1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      led         <= '0;
      hits        <= '0;
      misses      <= '0;
      round_done  <= 1'b0;
      game_over   <= 1'b0;
      round_count <= '0;
      tick_cnt    <= '0;
      show_len    <= '0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      led         <= led_n;
      hits        <= hits_n;
      misses      <= misses_n;
      round_done  <= round_done_n;
      game_over   <= game_over_n;
      round_count <= round_count_n;
      tick_cnt    <= tick_cnt_n;
      show_len    <= show_len_n;
      busy        <= (state_n != IDLE);
    end
  end

  always_comb begin
    state_n       = state;
    led_n         = led;
    hits_n        = '0;
    misses_n      = '0;
    round_done_n  = 1'b0;
    game_over_n   = 1'b0;
    round_count_n = round_count;
    tick_cnt_n    = tick_cnt;
    show_len_n    = show_len;
    lfsr_step     = 1'b0;
    unique case (state)
      IDLE: begin
        led_n = '0;
        if (start) begin
          state_n       = SPAWN;
          round_count_n = '0;
        end
      end
      SPAWN: begin
        led_n      = N_LEDS'(mole_mask(lfsr_q, difficulty));
        show_len_n = (show_scaled == '0) ? 8'd1 : show_scaled;
        tick_cnt_n = '0;
        lfsr_step  = 1'b1;
        state_n    = SHOW;
      end
      SHOW: begin
        hits_n   = led & whacked;
        misses_n = ~led & whacked;
        led_n    = led & ~whacked;
        if (tick) tick_cnt_n = tick_cnt + 8'd1;
        // round_done/game_over are registered on the way in so both are
        // visible during the single CLEAR cycle.
        if ((tick && tick_cnt == show_len - 8'd1) || led_n == '0) begin
          state_n      = CLEAR;
          round_done_n = 1'b1;
          game_over_n  = last_round;
        end
      end
      CLEAR: begin
        led_n      = '0;
        tick_cnt_n = '0;
        if (round_count != ROUNDS) round_count_n = round_count + 8'd1;
        state_n = last_round ? IDLE : GAP;
      end
      GAP: begin
        led_n = '0;
        if (!start) begin
          state_n = IDLE;
        end else if (GAP_TICKS == 0) begin
          state_n = SPAWN;
        end else if (tick) begin
          tick_cnt_n = tick_cnt + 8'd1;
          if (tick_cnt == GAP_LAST) state_n = SPAWN;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mole_spawner.sv
// Directed self-checking bench for mole_spawner with hand-computed vectors.
module tb_mole_spawner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        tick = 1'b0;
  logic [1:0]  difficulty = 2'd0;
  logic [17:0] whacked = '0;
  logic [17:0] led, hits, misses;
  logic        round_done, game_over, busy;
  logic [7:0]  round_count;

  int checks = 0;
  int errors = 0;

  mole_spawner #(
    .N_LEDS     (18),
    .SEED       (16'hACE1),
    .SHOW_TICKS (8),
    .GAP_TICKS  (2),
    .N_ROUNDS   (3)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .tick        (tick),
    .difficulty  (difficulty),
    .whacked     (whacked),
    .led         (led),
    .hits        (hits),
    .misses      (misses),
    .round_done  (round_done),
    .game_over   (game_over),
    .round_count (round_count),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic clk1();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    start = 1'b0; tick = 1'b0; whacked = '0;
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clk1();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int rd_cnt, go_cnt;
    bit seen_go, go_with_rd, go_any;

    // Reset values
    do_reset();
    check_eq("rst_led", led, 0);
    check_eq("rst_hits", hits, 0);
    check_eq("rst_misses", misses, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_rc", round_count, 0);
    check_eq("rst_rd_go", {round_done, game_over}, 0);

    // Single mole, difficulty 0: SEED field f0 = 1 -> led bit 1
    difficulty = 2'd0; start = 1'b1;
    clk1();
    check_eq("spawn_busy", busy, 1);
    check_eq("spawn_led", led, 0);
    clk1();
    check_eq("single_led", led, 18'h00002);
    tick = 1'b1;
    for (int i = 0; i < 7; i++) clk1();
    check_eq("single_hold_led", led, 18'h00002);
    check_eq("single_hold_rd", round_done, 0);
    clk1();
    check_eq("single_rd", round_done, 1);
    tick = 1'b0;
    clk1();
    check_eq("single_gap_led", led, 0);
    check_eq("single_gap_rd", round_done, 0);
    check_eq("single_gap_rc", round_count, 1);
    // Second round, then asynchronous reset mid-SHOW
    tick = 1'b1;
    clk1();
    clk1();
    tick = 1'b0;
    clk1();
    check_eq("r2_led_lit", (led != 0), 1);
    check_eq("r2_rc", round_count, 1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("async_led", led, 0);
    check_eq("async_busy", busy, 0);
    check_eq("async_rc", round_count, 0);
    #2 rst_n = 1'b1;

    // Triple mole, partial whack, miss, timeout race, abort in GAP
    do_reset();
    difficulty = 2'd2; start = 1'b1;
    clk1();
    clk1();
    check_eq("tri_led", led, 18'h00882);
    whacked = 18'h00080;
    clk1();
    check_eq("tri_hits", hits, 18'h00080);
    check_eq("tri_led_after", led, 18'h00802);
    check_eq("tri_misses0", misses, 0);
    whacked = 18'h00001;
    clk1();
    check_eq("tri_misses", misses, 18'h00001);
    check_eq("tri_hits0", hits, 0);
    check_eq("tri_led_keep", led, 18'h00802);
    whacked = '0; tick = 1'b1;
    clk1();
    check_eq("tri_tick1_rd", round_done, 0);
    whacked = 18'h00002;
    clk1();
    check_eq("race_rd", round_done, 1);
    check_eq("race_hits", hits, 18'h00002);
    check_eq("race_go", game_over, 0);
    whacked = '0; tick = 1'b0; start = 1'b0;
    clk1();
    check_eq("abort_gap_busy", busy, 1);
    check_eq("abort_gap_hits", hits, 0);
    clk1();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_go", game_over, 0);
    check_eq("abort_rc", round_count, 1);

    // Early clear: whack every lit mole in the first SHOW cycle
    do_reset();
    difficulty = 2'd2; start = 1'b1;
    clk1();
    clk1();
    whacked = 18'h00882;
    clk1();
    check_eq("early_rd", round_done, 1);
    check_eq("early_hits", hits, 18'h00882);
    check_eq("early_misses", misses, 0);
    whacked = '0;
    clk1();
    check_eq("early_hits_gone", hits, 0);
    check_eq("early_led", led, 0);

    // Full 3-round game, start held, no whacks, difficulty 3 (show_len 1)
    do_reset();
    difficulty = 2'd3; start = 1'b1; tick = 1'b1;
    rd_cnt = 0; go_cnt = 0; seen_go = 0; go_with_rd = 0; go_any = 0;
    for (int i = 0; i < 60 && !seen_go; i++) begin
      clk1();
      if (round_done) rd_cnt++;
      if (game_over) begin
        go_cnt++;
        seen_go = 1;
        go_with_rd = round_done;
      end
    end
    check_eq("game_over_seen", seen_go, 1);
    check_eq("game_rd_count", rd_cnt, 3);
    check_eq("game_go_count", go_cnt, 1);
    check_eq("game_go_with_rd", go_with_rd, 1);
    clk1();
    check_eq("game_end_rc", round_count, 3);
    check_eq("game_end_busy", busy, 0);
    check_eq("game_end_go", game_over, 0);
    clk1();
    check_eq("restart_busy", busy, 1);
    check_eq("restart_rc", round_count, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
